tnn_neuron_serial: RTL and testbench
====================================

Name: tnn_neuron_serial

Overview:
- Parametrised, sequential successor to the single-neuron combinational comparators in the TNN approximate-circuit library.
- Accepts one input vector of N_INPUTS unsigned IN_W-bit activations per transaction.
- Computes the exact signed ternary-weighted sum (+1/-1 per input, fixed by mask), LANES inputs per cycle, and compares it with THRESHOLD.
- Emits a 1-bit decision plus the raw sum through a valid/ready handshake. Serves as the exact golden neuron and the area-scalable drop-in for wider layers.

Parameters:
N_INPUTS, 7, number of activations per vector (>=1)
IN_W, 2, bits per activation, unsigned
LANES, 1, activations summed per cycle (1..N_INPUTS)
POS_MASK, 7'b1011101, N_INPUTS bits; bit i=1 -> weight +1, 0 -> weight -1 for input i
THRESHOLD, 0, signed 32-bit; out_bit = (sum >= THRESHOLD)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  N_INPUTS*IN_W  packed activations; input i at bits [i*IN_W +: IN_W]
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_bit  out  1  neuron decision
out_sum  out  ACC_W  signed weighted sum; ACC_W = clog2(N_INPUTS*(2^IN_W-1)+1)+1

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Sampled on rising edge, overrides all other activity including mid-transaction.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bit=0, out_sum=0, accumulator=0, lane index=0.
- K = ceil(N_INPUTS/LANES).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data, clear accumulator, set index=0, go to ACCUM.
- ACCUM:
  - in_ready=0.
  - Each cycle, add the signed sum of inputs index*LANES .. index*LANES+LANES-1 to the accumulator. Inputs at positions >= N_INPUTS contribute 0 (last-beat padding).
  - index increments each cycle.
  - After the K-th add: register out_sum=final accumulator and out_bit=(out_sum >= THRESHOLD, signed compare, THRESHOLD sign-extended/truncated to ACC_W+1). Set out_valid=1 and go to DONE.
- DONE:
  - out_valid=1. out_bit and out_sum are held stable until out_ready=1.
  - On out_valid&out_ready: out_valid=0 next cycle, go to IDLE.
  - in_ready stays 0 in DONE; no overlap between transactions.
- Latency: if the vector is accepted at edge T, out_valid is first seen high after edge T+K.
- Throughput: one vector per K+2 cycles with out_ready held at 1.
- in_data is ignored outside the accept cycle. Changing in_data after acceptance has no effect.
- Arithmetic: exact, no saturation. ACC_W is sized so that the worst-case ±N_INPUTS*(2^IN_W-1) fits.
- A reset asserted in ACCUM or DONE discards the transaction. No out_valid pulse follows.
- in_valid asserted while in_ready=0 is ignored; the sender must hold it.

Decomposition:
- Package tnn_pkg: state enum {IDLE, ACCUM, DONE}; function acc_width(n, w); function num_beats(n, lanes).
- Sub-module tnn_lane_adder: combinational. Takes LANES activations, their LANES mask bits and a per-lane valid, and returns a signed ACC_W partial sum. Instantiated once in tnn_neuron_serial.

Test Plan:
- Defaults, in_data all inputs=3, out_ready=1 -> sum=15-6=9, out_bit=1; out_valid first high 7 edges after the accept edge, for 1 cycle; in_ready high again the following cycle.
- Defaults, inputs 1 and 5 (b,f)=3, rest 0 -> out_sum=-6, out_bit=0. All zeros -> out_sum=0, out_bit=1 (boundary sum==THRESHOLD).
- THRESHOLD=10, all inputs=3 -> out_sum=9, out_bit=0. THRESHOLD=9 -> out_bit=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_sum, out_bit stable and in_ready=0 throughout; release -> handshake completes, IDLE.
- LANES=3, N_INPUTS=7, random vectors (1000) -> K=3 beats with padding; out_sum matches reference model each time; latency 3 edges.
- rst pulsed during the 4th ACCUM cycle with LANES=1 -> next cycle in_ready=1, out_valid=0, out_sum=0; a new vector then completes correctly.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared types and sizing helpers for the serial ternary neuron.
package tnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

    // Signed width that holds +/- n*(2^w-1) exactly.
    function automatic int acc_width(input int n, input int w);
        return $clog2(n * ((1 << w) - 1) + 1) + 1;
    endfunction

    function automatic int num_beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/tnn_lane_adder.sv
// Combinational signed partial sum of LANES activations with +1/-1 weights.
module tnn_lane_adder
    import tnn_pkg::*;
#(
    parameter int LANES = 1,
    parameter int IN_W  = 2,
    parameter int ACC_W = 6
) (
    input  logic [LANES*IN_W-1:0]   act,
    input  logic [LANES-1:0]        pos,
    input  logic [LANES-1:0]        lane_vld,
    output logic signed [ACC_W-1:0] psum
);

    always_comb begin
        psum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_vld[l]) begin
                if (pos[l]) begin
                    psum = psum + ACC_W'(act[l*IN_W +: IN_W]);
                end else begin
                    psum = psum - ACC_W'(act[l*IN_W +: IN_W]);
                end
            end
        end
    end

endmodule

// File: rtl/tnn_neuron_serial.sv
// Exact ternary-weighted neuron, LANES activations per cycle, valid/ready on both sides.
module tnn_neuron_serial
    import tnn_pkg::*;
#(
    parameter int                  N_INPUTS  = 7,
    parameter int                  IN_W      = 2,
    parameter int                  LANES     = 1,
    parameter logic [N_INPUTS-1:0] POS_MASK  = 7'b1011101,
    parameter int                  THRESHOLD = 0,
    localparam int                 ACC_W     = acc_width(N_INPUTS, IN_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_INPUTS*IN_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_bit,
    output logic [ACC_W-1:0]         out_sum
);

    localparam int K     = num_beats(N_INPUTS, LANES);
    localparam int PAD_N = K * LANES;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic signed [ACC_W:0] THR_X = (ACC_W + 1)'(THRESHOLD);

    state_e                    state_q, state_d;
    logic [N_INPUTS*IN_W-1:0]  data_q, data_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      bit_q, bit_d;

    logic [PAD_N*IN_W-1:0]     data_pad;
    logic [PAD_N-1:0]          mask_pad;
    logic [LANES*IN_W-1:0]     lane_act;
    logic [LANES-1:0]          lane_pos;
    logic [LANES-1:0]          lane_vld;
    logic signed [ACC_W-1:0]   psum;
    logic signed [ACC_W-1:0]   acc_next;
    int                        base_lane;

    // Zero-padded to a whole number of beats so the last beat can slice past N_INPUTS.
    assign data_pad = (PAD_N * IN_W)'(data_q);
    assign mask_pad = PAD_N'(POS_MASK);

    always_comb begin
        base_lane = int'(idx_q) * LANES;
        lane_act  = (LANES * IN_W)'(data_pad >> (base_lane * IN_W));
        lane_pos  = LANES'(mask_pad >> base_lane);
        for (int l = 0; l < LANES; l++) begin
            lane_vld[l] = (base_lane + l) < N_INPUTS;
        end
    end

    tnn_lane_adder #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_lane_adder (
        .act      (lane_act),
        .pos      (lane_pos),
        .lane_vld (lane_vld),
        .psum     (psum)
    );

    assign acc_next = acc_q + psum;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        bit_d     = bit_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(K - 1)) begin
                    sum_d   = acc_next;
                    bit_d   = $signed({acc_next[ACC_W-1], acc_next}) >= THR_X;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            bit_q   <= bit_d;
        end
    end

    assign out_sum = sum_q;
    assign out_bit = bit_q;

endmodule

// File: tb/tb_tnn_neuron_serial.sv
// Scoreboard bench: three neuron configurations checked against an arithmetic reference model.
module tb_tnn_neuron_serial;

    localparam int         AW   = 6;
    localparam logic [6:0] MASK = 7'b1011101;
    localparam int LANES_A [3] = '{1, 1, 3};
    localparam int THR_A   [3] = '{0, 10, 9};
    localparam int K_A     [3] = '{7, 7, 3};

    typedef struct {
        int   dut;
        int   sum;
        logic b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          iv   [3];
    logic          ir   [3];
    logic          ov   [3];
    logic          ordy [3];
    logic          ob   [3];
    logic [13:0]   idata[3];
    logic [AW-1:0] osum [3];

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tnn_neuron_serial #(.LANES(1), .THRESHOLD(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_bit(ob[0]), .out_sum(osum[0]));
    tnn_neuron_serial #(.LANES(1), .THRESHOLD(10)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_bit(ob[1]), .out_sum(osum[1]));
    tnn_neuron_serial #(.LANES(3), .THRESHOLD(9)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idata[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_bit(ob[2]), .out_sum(osum[2]));

    function automatic int ref_sum(input logic [13:0] v);
        int s;
        int a;
        s = 0;
        for (int i = 0; i < 7; i++) begin
            a = int'(v[i*2 +: 2]);
            s = MASK[i] ? s + a : s - a;
        end
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (ov[d] && ordy[d]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", d, -1);
                end else begin
                    e = sb.pop_front();
                    chk("out_dut", d, e.dut);
                    chk("out_sum", int'($signed(osum[d])), e.sum);
                    chk("out_bit", int'(ob[d]), int'(e.b));
                end
            end
        end
    end

    task automatic send(input int d, input logic [13:0] v, input bit tail);
        int n;
        int s;
        exp_t e;
        s = ref_sum(v);
        n = 0;
        while (!ir[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", int'(n < 50), 1);
        idata[d] = v;
        iv[d]    = 1'b1;
        e.dut = d; e.sum = s; e.b = (s >= THR_A[d]);
        sb.push_back(e);
        @(posedge clk); #1;
        iv[d]    = 1'b0;
        idata[d] = 14'($urandom);
        n = 0;
        while (!ov[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, K_A[d]);
        if (tail) begin
            @(posedge clk); #1;
            chk("ov_drop", int'(ov[d]), 0);
            chk("ready_back", int'(ir[d]), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [13:0] bf;
        int          s;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; idata[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", int'(ir[d]), 1);
            chk("rst_out_valid", int'(ov[d]), 0);
            chk("rst_out_sum", int'(osum[d]), 0);
            chk("rst_out_bit", int'(ob[d]), 0);
        end

        send(0, 14'h3FFF, 1);
        bf = '0;
        bf[3:2]   = 2'd3;
        bf[11:10] = 2'd3;
        send(0, bf, 1);
        send(0, 14'h0000, 1);
        send(1, 14'h3FFF, 1);
        send(2, 14'h3FFF, 1);

        // Backpressure: result must hold while the consumer stalls.
        ordy[0] = 1'b0;
        s = ref_sum(14'h3FFF);
        send(0, 14'h3FFF, 0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", int'(ov[0]), 1);
            chk("bp_sum", int'($signed(osum[0])), s);
            chk("bp_bit", int'(ob[0]), int'(s >= THR_A[0]));
            chk("bp_in_ready", int'(ir[0]), 0);
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(ov[0]), 0);
        chk("bp_release_ready", int'(ir[0]), 1);

        // Reset in the 4th accumulate cycle discards the transaction.
        idata[0] = 14'h3FFF;
        iv[0]    = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", int'(ir[0]), 1);
        chk("mid_rst_out_valid", int'(ov[0]), 0);
        chk("mid_rst_out_sum", int'(osum[0]), 0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_pulse", int'(ov[0]), 0);
        end
        send(0, 14'($urandom), 1);

        for (int t = 0; t < 1000; t++) begin
            send(2, 14'($urandom), 1);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
